// File: rtl/cordic_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// cordic_share_arbiter_if
//   One AXI-Stream channel (valid/ready handshake, last, data, strobe).
//   master : drives tvalid/tlast/tdata/tstrb, receives tready
//   slave  : receives tvalid/tlast/tdata/tstrb, drives tready
// -----------------------------------------------------------------------------
interface cordic_share_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;

    modport master (
        output tvalid,
        output tlast,
        output tdata,
        output tstrb,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tlast,
        input  tdata,
        input  tstrb,
        output tready
    );
endinterface

// File: rtl/cordic_share_arbiter.sv
// -----------------------------------------------------------------------------
// cordic_share_arbiter
//   Time-shares one pipelined CORDIC between two AXI-Stream requesters.
//   Requests are arbitrated round-robin with packet locking on tlast and sent
//   through a one-beat issue register. The requester ID of every issued beat
//   is queued in a tag FIFO so returning results are steered back in order.
//
// Ports
//   s00_axis_aclk     single clock
//   s00_axis_aresetn  asynchronous active-low reset
//   s00_axis          requester 0 request stream (Costas I/Q derotation)
//   s01_axis          requester 1 request stream (RDS magnitude/phase)
//   m00_axis          request stream to the CORDIC
//   s02_axis          result stream from the CORDIC
//   m01_axis          result stream to requester 0
//   m02_axis          result stream to requester 1
//   outstanding       beats issued but not yet returned
//   err_orphan        sticky: a result arrived with no tag queued
// -----------------------------------------------------------------------------
module cordic_share_arbiter #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 16
) (
    input  logic                                 s00_axis_aclk,
    input  logic                                 s00_axis_aresetn,
    cordic_share_arbiter_if.slave                s00_axis,
    cordic_share_arbiter_if.slave                s01_axis,
    cordic_share_arbiter_if.master               m00_axis,
    cordic_share_arbiter_if.slave                s02_axis,
    cordic_share_arbiter_if.master               m01_axis,
    cordic_share_arbiter_if.master               m02_axis,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 err_orphan
);

    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        StIdle,
        StLock0,
        StLock1
    } arb_state_e;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    arb_state_e state_q, state_d;
    logic       prio_q, prio_d;     // 0: requester 0 wins a tie in StIdle

    // Holds both treadys low while reset is asserted and for the first edge
    // after release, so nothing is accepted until state is known.
    logic run_q;

    logic grant0, grant1;
    logic rdy0, rdy1;
    logic acc0, acc1;
    logic issue_free, credit_ok;

    logic                  issue_valid_q;
    logic                  issue_last_q;
    logic [DATA_WIDTH-1:0] issue_data_q;

    logic            tag_mem_q [MAX_OUTSTANDING];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop, push_id;
    logic            fifo_empty, head_id;
    logic            res_rdy;

    logic err_orphan_q;

    // -------------------------------------------------------------------------
    // Arbiter FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q <= StIdle;
            prio_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            run_q   <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Arbiter FSM: next state. A packet's final beat always hands priority to
    // the other requester, whether the packet was one beat or several.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        unique case (state_q)
            StIdle: begin
                if (acc0) begin
                    if (s00_axis.tlast) prio_d = 1'b1;
                    else                state_d = StLock0;
                end else if (acc1) begin
                    if (s01_axis.tlast) prio_d = 1'b0;
                    else                state_d = StLock1;
                end
            end
            StLock0: begin
                if (acc0 && s00_axis.tlast) begin
                    state_d = StIdle;
                    prio_d  = 1'b1;
                end
            end
            StLock1: begin
                if (acc1 && s01_axis.tlast) begin
                    state_d = StIdle;
                    prio_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // -------------------------------------------------------------------------
    // Arbiter FSM: outputs (grants). Grants never look at tdata.
    // -------------------------------------------------------------------------
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s00_axis.tvalid && s01_axis.tvalid) begin
                    grant0 = ~prio_q;
                    grant1 = prio_q;
                end else begin
                    grant0 = s00_axis.tvalid;
                    grant1 = s01_axis.tvalid;
                end
            end
            StLock0: grant0 = 1'b1;
            StLock1: grant1 = 1'b1;
            default: ;
        endcase
    end

    assign issue_free = ~issue_valid_q | m00_axis.tready;
    assign credit_ok  = (count_q < MaxCnt);

    assign rdy0 = run_q & grant0 & issue_free & credit_ok;
    assign rdy1 = run_q & grant1 & issue_free & credit_ok;
    assign acc0 = s00_axis.tvalid & rdy0;
    assign acc1 = s01_axis.tvalid & rdy1;

    assign s00_axis.tready = rdy0;
    assign s01_axis.tready = rdy1;

    // -------------------------------------------------------------------------
    // Issue register. Accepts only when free, so a held beat is never lost.
    // -------------------------------------------------------------------------
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            issue_valid_q <= 1'b0;
            issue_last_q  <= 1'b0;
            issue_data_q  <= '0;
        end else if (acc0 || acc1) begin
            issue_valid_q <= 1'b1;
            issue_last_q  <= acc1 ? s01_axis.tlast : s00_axis.tlast;
            issue_data_q  <= acc1 ? s01_axis.tdata : s00_axis.tdata;
        end else if (m00_axis.tready) begin
            issue_valid_q <= 1'b0;
        end
    end

    assign m00_axis.tvalid = issue_valid_q;
    assign m00_axis.tlast  = issue_last_q;
    assign m00_axis.tdata  = issue_data_q;
    assign m00_axis.tstrb  = '1;

    // -------------------------------------------------------------------------
    // Tag FIFO. The count doubles as the credit counter: a tag is pushed when
    // the request is accepted, not when it leaves the issue register.
    // -------------------------------------------------------------------------
    assign push       = acc0 | acc1;
    assign push_id    = acc1;
    assign fifo_empty = (count_q == '0);
    assign head_id    = tag_mem_q[rd_ptr_q];
    assign pop        = s02_axis.tvalid & res_rdy;

    always_ff @(posedge s00_axis_aclk) begin
        if (push) tag_mem_q[wr_ptr_q] <= push_id;
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

    assign outstanding = count_q;

    // -------------------------------------------------------------------------
    // Return path. A stalled destination stalls every result so order holds.
    // With no tag queued the result is refused and flagged as an orphan.
    // -------------------------------------------------------------------------
    assign res_rdy         = ~fifo_empty & (head_id ? m02_axis.tready : m01_axis.tready);
    assign s02_axis.tready = res_rdy;

    assign m01_axis.tvalid = s02_axis.tvalid & ~fifo_empty & ~head_id;
    assign m01_axis.tlast  = s02_axis.tlast;
    assign m01_axis.tdata  = s02_axis.tdata;
    assign m01_axis.tstrb  = '1;

    assign m02_axis.tvalid = s02_axis.tvalid & ~fifo_empty & head_id;
    assign m02_axis.tlast  = s02_axis.tlast;
    assign m02_axis.tdata  = s02_axis.tdata;
    assign m02_axis.tstrb  = '1;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            err_orphan_q <= 1'b0;
        end else if (s02_axis.tvalid && fifo_empty) begin
            err_orphan_q <= 1'b1;
        end
    end

    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_cordic_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cordic_share_arbiter
//   Directed bench for cordic_share_arbiter. A small CORDIC model (fixed
//   latency, result = request + 0x1000_0000) sits on m00/s02. Inputs are
//   driven on the falling edge and outputs sampled shortly after.
// -----------------------------------------------------------------------------
module tb_cordic_share_arbiter;

    localparam int unsigned DW  = 32;
    localparam int          Lat = 8;
    localparam logic [31:0] K   = 32'h1000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cordic_share_arbiter_if #(.DATA_WIDTH(DW)) s00_if ();
    cordic_share_arbiter_if #(.DATA_WIDTH(DW)) s01_if ();
    cordic_share_arbiter_if #(.DATA_WIDTH(DW)) m00_if ();
    cordic_share_arbiter_if #(.DATA_WIDTH(DW)) s02_if ();
    cordic_share_arbiter_if #(.DATA_WIDTH(DW)) m01_if ();
    cordic_share_arbiter_if #(.DATA_WIDTH(DW)) m02_if ();

    logic [4:0] outstanding;
    logic       err_orphan;

    cordic_share_arbiter #(
        .DATA_WIDTH     (DW),
        .MAX_OUTSTANDING(16)
    ) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_aresetn(rst_n),
        .s00_axis        (s00_if),
        .s01_axis        (s01_if),
        .m00_axis        (m00_if),
        .s02_axis        (s02_if),
        .m01_axis        (m01_if),
        .m02_axis        (m02_if),
        .outstanding     (outstanding),
        .err_orphan      (err_orphan)
    );

    int checks = 0;
    int errors = 0;

    // Written by the main sequence
    logic [32:0] req0_q[$];
    logic [32:0] req1_q[$];
    bit          m01_rdy = 1'b1;
    bit          m02_rdy = 1'b1;
    bit          acc0, acc1;
    logic [31:0] acc0_data;
    int          peak;
    int          ret_limit = 1 << 30;
    bit          inject = 1'b0;
    bit          m00_rdy_en = 1'b1;

    // Written by the CORDIC model
    logic [32:0] pipe_q[$];
    int          pipe_due[$];
    int          cyc = 0;
    int          ret_count = 0;
    bit          model_inj;
    logic [31:0] m00_log[$];
    logic [31:0] m01_log[$];
    logic [31:0] m02_log[$];
    int          route_log[$];

    // -------------------------------------------------------------------------
    // CORDIC model and output monitors
    // -------------------------------------------------------------------------
    initial begin : cordic_model
        s02_if.tvalid = 1'b0;
        s02_if.tdata  = '0;
        s02_if.tlast  = 1'b0;
        s02_if.tstrb  = '1;
        m00_if.tready = 1'b0;
        forever begin
            @(negedge clk);
            model_inj = inject;
            if (!rst_n) begin
                pipe_q.delete();
                pipe_due.delete();
            end
            m00_if.tready = m00_rdy_en & rst_n;
            if (model_inj) begin
                s02_if.tvalid = 1'b1;
                s02_if.tdata  = 32'hDEAD_BEEF;
                s02_if.tlast  = 1'b1;
            end else if (pipe_q.size() > 0 && pipe_due[0] <= cyc && ret_count < ret_limit) begin
                s02_if.tvalid = 1'b1;
                s02_if.tdata  = pipe_q[0][31:0] + K;
                s02_if.tlast  = pipe_q[0][32];
            end else begin
                s02_if.tvalid = 1'b0;
            end
            #2;
            if (rst_n) begin
                if (s02_if.tvalid && s02_if.tready && !model_inj) begin
                    void'(pipe_q.pop_front());
                    void'(pipe_due.pop_front());
                    ret_count++;
                end
                if (m00_if.tvalid && m00_if.tready) begin
                    pipe_q.push_back({m00_if.tlast, m00_if.tdata});
                    pipe_due.push_back(cyc + Lat);
                    m00_log.push_back(m00_if.tdata);
                end
                if (m01_if.tvalid && m01_if.tready) begin
                    m01_log.push_back(m01_if.tdata);
                    route_log.push_back(1);
                end
                if (m02_if.tvalid && m02_if.tready) begin
                    m02_log.push_back(m02_if.tdata);
                    route_log.push_back(2);
                end
            end
            cyc++;
        end
    end

    // -------------------------------------------------------------------------
    // One clock of requester stimulus; returns just after the falling edge
    // with acc0/acc1 telling whether each presented beat will be taken.
    // -------------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
        s00_if.tvalid = (req0_q.size() > 0);
        s00_if.tdata  = (req0_q.size() > 0) ? req0_q[0][31:0] : 32'h0;
        s00_if.tlast  = (req0_q.size() > 0) ? req0_q[0][32] : 1'b0;
        s01_if.tvalid = (req1_q.size() > 0);
        s01_if.tdata  = (req1_q.size() > 0) ? req1_q[0][31:0] : 32'h0;
        s01_if.tlast  = (req1_q.size() > 0) ? req1_q[0][32] : 1'b0;
        m01_if.tready = m01_rdy;
        m02_if.tready = m02_rdy;
        #1;
        acc0 = s00_if.tvalid && s00_if.tready;
        acc1 = s01_if.tvalid && s01_if.tready;
        if (acc0) begin
            acc0_data = req0_q[0][31:0];
            void'(req0_q.pop_front());
        end
        if (acc1) void'(req1_q.pop_front());
        if (int'(outstanding) > peak) peak = int'(outstanding);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0_q.delete();
        req1_q.delete();
        s00_if.tvalid = 1'b0;
        s01_if.tvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        s00_if.tvalid = 1'b1;
        s00_if.tdata  = 32'h55;
        s00_if.tlast  = 1'b1;
        s00_if.tstrb  = '1;
        s01_if.tvalid = 1'b1;
        s01_if.tdata  = 32'h66;
        s01_if.tlast  = 1'b1;
        s01_if.tstrb  = '1;
        m01_if.tready = 1'b1;
        m02_if.tready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (s00_if.tready !== 1'b0) begin
            errors++; $display("FAIL reset_s00_tready: got %0b expected 0", s00_if.tready);
        end
        checks++;
        if (s01_if.tready !== 1'b0) begin
            errors++; $display("FAIL reset_s01_tready: got %0b expected 0", s01_if.tready);
        end
        checks++;
        if (m00_if.tvalid !== 1'b0) begin
            errors++; $display("FAIL reset_m00_tvalid: got %0b expected 0", m00_if.tvalid);
        end
        checks++;
        if (s02_if.tready !== 1'b0) begin
            errors++; $display("FAIL reset_s02_tready: got %0b expected 0", s02_if.tready);
        end
        checks++;
        if (m01_if.tvalid !== 1'b0 || m02_if.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp_tvalid: got %0b%0b expected 00", m01_if.tvalid, m02_if.tvalid);
        end
        checks++;
        if (outstanding !== 5'd0) begin
            errors++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding);
        end
        checks++;
        if (err_orphan !== 1'b0) begin
            errors++; $display("FAIL reset_err_orphan: got %0b expected 0", err_orphan);
        end
        @(negedge clk);
        rst_n = 1'b1;
        s00_if.tvalid = 1'b0;
        s01_if.tvalid = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_single_req0();
        int          b00, b01, b02;
        bit          pend;
        logic [31:0] pend_data;
        b00  = m00_log.size();
        b01  = m01_log.size();
        b02  = m02_log.size();
        peak = 0;
        pend = 1'b0;
        for (int i = 0; i < 4; i++) req0_q.push_back({1'b1, 32'h11 + i});
        for (int i = 0; i < 200 && (m01_log.size() - b01) < 4; i++) begin
            step();
            if (pend) begin
                checks++;
                if (m00_if.tvalid !== 1'b1 || m00_if.tdata !== pend_data) begin
                    errors++;
                    $display("FAIL single_issue_latency: got v=%0b d=%0h expected v=1 d=%0h",
                             m00_if.tvalid, m00_if.tdata, pend_data);
                end
            end
            pend      = acc0;
            pend_data = acc0_data;
        end
        repeat (2) step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m00_log[b00 + i] !== 32'h11 + i) begin
                errors++;
                $display("FAIL single_m00_%0d: got %0h expected %0h", i, m00_log[b00 + i], 32'h11 + i);
            end
            checks++;
            if (m01_log[b01 + i] !== 32'h11 + i + K) begin
                errors++;
                $display("FAIL single_m01_%0d: got %0h expected %0h", i, m01_log[b01 + i],
                         32'h11 + i + K);
            end
        end
        checks++;
        if (m02_log.size() != b02) begin
            errors++; $display("FAIL single_m02_count: got %0d expected 0", m02_log.size() - b02);
        end
        checks++;
        if (peak != 4) begin
            errors++; $display("FAIL single_peak_outstanding: got %0d expected 4", peak);
        end
        checks++;
        if (outstanding !== 5'd0) begin
            errors++; $display("FAIL single_final_outstanding: got %0d expected 0", outstanding);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_alternate();
        int          b00, b01, b02;
        logic [31:0] exp_seq [8];
        do_reset();
        b00 = m00_log.size();
        b01 = m01_log.size();
        b02 = m02_log.size();
        for (int i = 0; i < 4; i++) begin
            req0_q.push_back({1'b1, 32'hA0 + i});
            req1_q.push_back({1'b1, 32'hB0 + i});
            exp_seq[2 * i]     = 32'hA0 + i;
            exp_seq[2 * i + 1] = 32'hB0 + i;
        end
        for (int i = 0; i < 300 && (m01_log.size() - b01 + m02_log.size() - b02) < 8; i++) step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (m00_log[b00 + i] !== exp_seq[i]) begin
                errors++;
                $display("FAIL alt_order_%0d: got %0h expected %0h", i, m00_log[b00 + i], exp_seq[i]);
            end
        end
        checks++;
        if (m01_log[b01] !== 32'hA0 + K) begin
            errors++; $display("FAIL alt_m01_first: got %0h expected %0h", m01_log[b01], 32'hA0 + K);
        end
        checks++;
        if (m02_log[b02 + 3] !== 32'hB3 + K) begin
            errors++;
            $display("FAIL alt_m02_last: got %0h expected %0h", m02_log[b02 + 3], 32'hB3 + K);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_lock();
        int          b00;
        int          c_acc;
        bit          locked;
        logic [31:0] exp_seq [5];
        do_reset();
        b00   = m00_log.size();
        c_acc = 0;
        req0_q.push_back({1'b0, 32'hC0});
        req0_q.push_back({1'b0, 32'hC1});
        req0_q.push_back({1'b1, 32'hC2});
        req1_q.push_back({1'b1, 32'hD0});
        req1_q.push_back({1'b1, 32'hD1});
        exp_seq = '{32'hC0, 32'hC1, 32'hC2, 32'hD0, 32'hD1};
        for (int i = 0; i < 100 && (m00_log.size() - b00) < 5; i++) begin
            locked = (c_acc == 1 || c_acc == 2);
            step();
            if (locked) begin
                checks++;
                if (s01_if.tready !== 1'b0 || s01_if.tvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL lock_s01_tready: got rdy=%0b vld=%0b expected rdy=0 vld=1",
                             s01_if.tready, s01_if.tvalid);
                end
            end
            if (acc0) c_acc++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (m00_log[b00 + i] !== exp_seq[i]) begin
                errors++;
                $display("FAIL lock_order_%0d: got %0h expected %0h", i, m00_log[b00 + i], exp_seq[i]);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_credit();
        int b00, b01, b02;
        do_reset();
        ret_limit = ret_count;
        b00 = m00_log.size();
        b01 = m01_log.size();
        b02 = m02_log.size();
        for (int i = 0; i < 20; i++) req0_q.push_back({1'b1, 32'h100 + i});
        req1_q.push_back({1'b1, 32'h200});
        repeat (40) step();
        checks++;
        if (outstanding !== 5'd16) begin
            errors++; $display("FAIL credit_full_outstanding: got %0d expected 16", outstanding);
        end
        checks++;
        if (m00_log.size() - b00 != 16) begin
            errors++; $display("FAIL credit_full_issued: got %0d expected 16", m00_log.size() - b00);
        end
        checks++;
        if (s00_if.tready !== 1'b0 || s01_if.tready !== 1'b0) begin
            errors++;
            $display("FAIL credit_full_treadys: got %0b%0b expected 00", s00_if.tready, s01_if.tready);
        end
        ret_limit = ret_count + 1;
        repeat (30) step();
        checks++;
        if (m00_log.size() - b00 != 17) begin
            errors++; $display("FAIL credit_one_more: got %0d expected 17", m00_log.size() - b00);
        end
        checks++;
        if (outstanding !== 5'd16) begin
            errors++; $display("FAIL credit_refill_outstanding: got %0d expected 16", outstanding);
        end
        checks++;
        if (s00_if.tready !== 1'b0 || s01_if.tready !== 1'b0) begin
            errors++;
            $display("FAIL credit_refill_treadys: got %0b%0b expected 00", s00_if.tready, s01_if.tready);
        end
        ret_limit = 1 << 30;
        for (int i = 0; i < 400 && ((req0_q.size() + req1_q.size()) > 0 || outstanding != 0); i++)
            step();
        repeat (3) step();
        checks++;
        if (outstanding !== 5'd0) begin
            errors++; $display("FAIL credit_drain_outstanding: got %0d expected 0", outstanding);
        end
        checks++;
        if (m01_log.size() - b01 != 20 || m02_log.size() - b02 != 1) begin
            errors++;
            $display("FAIL credit_drain_routing: got m01=%0d m02=%0d expected m01=20 m02=1",
                     m01_log.size() - b01, m02_log.size() - b02);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_backpressure();
        int b01, b02, brl;
        do_reset();
        b01     = m01_log.size();
        b02     = m02_log.size();
        m02_rdy = 1'b0;
        req1_q.push_back({1'b1, 32'hE0});
        for (int i = 0; i < 20 && req1_q.size() > 0; i++) step();
        req0_q.push_back({1'b1, 32'hF0});
        repeat (25) step();
        checks++;
        if (s02_if.tvalid !== 1'b1 || s02_if.tready !== 1'b0) begin
            errors++;
            $display("FAIL bp_s02_stall: got vld=%0b rdy=%0b expected vld=1 rdy=0",
                     s02_if.tvalid, s02_if.tready);
        end
        checks++;
        if (m02_if.tvalid !== 1'b1 || m01_if.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL bp_resp_valid: got m01=%0b m02=%0b expected m01=0 m02=1",
                     m01_if.tvalid, m02_if.tvalid);
        end
        checks++;
        if (m01_log.size() != b01 || m02_log.size() != b02) begin
            errors++;
            $display("FAIL bp_no_delivery: got m01=%0d m02=%0d expected 0 0",
                     m01_log.size() - b01, m02_log.size() - b02);
        end
        checks++;
        if (outstanding !== 5'd2) begin
            errors++; $display("FAIL bp_outstanding: got %0d expected 2", outstanding);
        end
        brl     = route_log.size();
        m02_rdy = 1'b1;
        for (int i = 0; i < 40 && (m01_log.size() - b01) < 1; i++) step();
        repeat (2) step();
        checks++;
        if (m02_log[b02] !== 32'hE0 + K) begin
            errors++; $display("FAIL bp_m02_data: got %0h expected %0h", m02_log[b02], 32'hE0 + K);
        end
        checks++;
        if (m01_log[b01] !== 32'hF0 + K) begin
            errors++; $display("FAIL bp_m01_data: got %0h expected %0h", m01_log[b01], 32'hF0 + K);
        end
        checks++;
        if (route_log[brl] != 2 || route_log[brl + 1] != 1) begin
            errors++;
            $display("FAIL bp_order: got %0d,%0d expected 2,1", route_log[brl], route_log[brl + 1]);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_orphan_and_reset();
        inject = 1'b1;
        step();
        checks++;
        if (s02_if.tready !== 1'b0) begin
            errors++; $display("FAIL orphan_s02_tready: got %0b expected 0", s02_if.tready);
        end
        checks++;
        if (m01_if.tvalid !== 1'b0 || m02_if.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL orphan_resp_valid: got %0b%0b expected 00", m01_if.tvalid, m02_if.tvalid);
        end
        checks++;
        if (err_orphan !== 1'b0) begin
            errors++; $display("FAIL orphan_err_early: got %0b expected 0", err_orphan);
        end
        step();
        checks++;
        if (err_orphan !== 1'b1) begin
            errors++; $display("FAIL orphan_err_set: got %0b expected 1", err_orphan);
        end
        inject = 1'b0;
        repeat (2) step();
        checks++;
        if (err_orphan !== 1'b1) begin
            errors++; $display("FAIL orphan_err_sticky: got %0b expected 1", err_orphan);
        end

        // Stall the CORDIC input so a beat sits in the issue register.
        m00_rdy_en = 1'b0;
        for (int i = 0; i < 3; i++) req0_q.push_back({1'b1, 32'h300 + i});
        repeat (4) step();
        checks++;
        if (m00_if.tvalid !== 1'b1 || m00_if.tdata !== 32'h300 || outstanding !== 5'd1) begin
            errors++;
            $display("FAIL hold_before_reset: got v=%0b d=%0h o=%0d expected v=1 d=300 o=1",
                     m00_if.tvalid, m00_if.tdata, outstanding);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m00_if.tvalid !== 1'b0) begin
            errors++; $display("FAIL midreset_m00_tvalid: got %0b expected 0", m00_if.tvalid);
        end
        checks++;
        if (s00_if.tready !== 1'b0 || s01_if.tready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_treadys: got %0b%0b expected 00", s00_if.tready, s01_if.tready);
        end
        checks++;
        if (outstanding !== 5'd0) begin
            errors++; $display("FAIL midreset_outstanding: got %0d expected 0", outstanding);
        end
        checks++;
        if (err_orphan !== 1'b0) begin
            errors++; $display("FAIL midreset_err_orphan: got %0b expected 0", err_orphan);
        end
        checks++;
        if (s02_if.tready !== 1'b0) begin
            errors++; $display("FAIL midreset_s02_tready: got %0b expected 0", s02_if.tready);
        end
        @(negedge clk);
        req0_q.delete();
        s00_if.tvalid = 1'b0;
        m00_rdy_en    = 1'b1;
        rst_n         = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_single_req0();
        test_alternate();
        test_lock();
        test_credit();
        test_backpressure();
        test_orphan_and_reset();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_share_arbiter.md
Name: cordic_share_arbiter

Overview:
- Time-shares one pipelined CORDIC between two AXI-Stream requesters: requester 0 is the Costas loop I/Q derotation, requester 1 is the RDS magnitude/phase path.
- Arbitrates requests round-robin with packet locking on tlast and issues them to the CORDIC through a one-beat output register.
- Records each issued beat's requester ID in a tag FIFO and steers returning CORDIC results back to the correct requester in order.

Parameters:
- DATA_WIDTH, 32, tdata width on all streams.
- MAX_OUTSTANDING, 16, tag FIFO depth and maximum beats issued but not yet returned; must be a power of 2 and ≥ CORDIC pipeline depth + 1.

Ports:
- s00_axis_aclk  in  1  single clock.
- s00_axis_aresetn  in  1  asynchronous active-low reset.
- s00_axis_tvalid/tready/tlast  in/out/in  1 each  requester 0 request stream.
- s00_axis_tdata  in  DATA_WIDTH  requester 0 request data.
- s01_axis_tvalid/tready/tlast  in/out/in  1 each  requester 1 request stream.
- s01_axis_tdata  in  DATA_WIDTH  requester 1 request data.
- m00_axis_tvalid/tready/tlast  out/in/out  1 each  request stream to CORDIC.
- m00_axis_tdata  out  DATA_WIDTH  request data to CORDIC.
- m00_axis_tstrb  out  DATA_WIDTH/8  constant all ones.
- s02_axis_tvalid/tready/tlast  in/out/in  1 each  result stream from CORDIC.
- s02_axis_tdata  in  DATA_WIDTH  CORDIC result data.
- m01_axis_tvalid/tready/tlast/tdata/tstrb  out/in/out/out/out  1/1/1/DATA_WIDTH/DATA_WIDTH/8  result stream to requester 0.
- m02_axis_tvalid/tready/tlast/tdata/tstrb  out/in/out/out/out  1/1/1/DATA_WIDTH/DATA_WIDTH/8  result stream to requester 1.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  beats issued but not returned.
- err_orphan  out  1  sticky: a result arrived while the tag FIFO was empty.

Behaviour:
- Reset (async assert, sync release):
  - All tvalid and tready outputs are 0; outstanding = 0; err_orphan = 0; tag FIFO empty.
  - Arbiter state = IDLE; round-robin priority = requester 0.
- Issue register:
  - Free when m00_axis_tvalid = 0 or m00_axis_tready = 1.
  - A request beat accepted in cycle N appears on m00 in cycle N+1, with tdata and tlast copied.
  - m00_axis_tvalid stays high and data is held stable until accepted.
- Arbiter FSM, states IDLE, LOCK0, LOCK1:
  - IDLE: if both requesters are valid, grant the priority holder; otherwise grant whichever is valid.
  - Accepting a beat with tlast = 0 moves to LOCKx. With tlast = 1, stay IDLE and flip priority to the other requester.
  - LOCKx: only requester x may be granted; the other requester's tready = 0.
  - In LOCKx, an accepted tlast = 1 beat returns to IDLE and sets priority to the other requester.
  - Requester x's tready = (x granted this cycle) AND (issue register free) AND (outstanding < MAX_OUTSTANDING).
  - tready depends only on state, the tvalids and the free/credit terms; never on that requester's own tdata.
- Tag FIFO and credit:
  - Push the requester ID on every accepted request beat; pop on every accepted result beat.
  - outstanding = pushes − pops. Simultaneous push and pop leaves it unchanged.
  - At outstanding = MAX_OUTSTANDING both treadys = 0; no overflow is possible.
  - FIFO pointers wrap modulo MAX_OUTSTANDING.
- Return path (combinational, zero latency):
  - head = FIFO head ID. m0(head+1)_axis_tvalid = s02_axis_tvalid AND FIFO not empty; the other response tvalid = 0.
  - s02_axis_tready = (FIFO not empty) AND (tready of the head's destination).
  - tdata and tlast pass straight through. Backpressure from one destination stalls all results, preserving order.
- Orphan results:
  - FIFO empty and s02_axis_tvalid = 1 → s02_axis_tready = 0 and no response valid.
  - err_orphan sets the next cycle and clears only on reset.
- Reset mid-operation: all in-flight tags and the held issue beat are discarded. The bench must also reset the CORDIC.

Test Plan:
- Only req0 sends 4 single-beat packets (tdata 0x11..0x14), CORDIC latency 8, all treadys high → m00 carries 0x11..0x14 one cycle after each accept; all 4 results appear on m01, none on m02; outstanding peaks at 4 and returns to 0.
- Both requesters send continuous single-beat packets (req0 0xA0.., req1 0xB0..) → m00 alternates A,B,A,B starting with A after reset.
- req0 sends a 3-beat packet (tlast on beat 3) while req1 is valid throughout → three consecutive req0 beats, then req1 granted; s01_axis_tready = 0 during LOCK0.
- Hold s02_axis_tvalid low and issue 16 beats → outstanding = 16, both treadys 0; release one result → exactly one further issue permitted.
- m02_axis_tready = 0 while the head tag = 1 and a req0 result is queued behind it → s02_axis_tready = 0 and m01 gets nothing until m02_axis_tready rises, then order is preserved.
- s02_axis_tvalid = 1 with an empty FIFO → s02_axis_tready = 0 and err_orphan = 1 next cycle; assert reset mid-stream → all outputs return to reset values asynchronously.
